// File: rtl/cnn_stream_pkg.sv
`default_nettype none
// ============================================================================
// cnn_stream_pkg : shared window geometry, idle select code and scan states
// Rev 1.0
// ============================================================================
package cnn_stream_pkg;

  localparam int NTAPS = 9;
  localparam int DW    = 8;
  localparam int SW    = 5;

  // Select code the downstream selector ignores, so its output holds.
  localparam logic [SW-1:0] IDLE_SEL = 5'd31;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/window_scan_ctrl.sv
`default_nettype none
// ============================================================================
// window_scan_ctrl : holds a 3x3 window and walks a registered 9:1 selector
// across its taps, one per cycle, with back-to-back window reload.
// Rev 1.0
// ============================================================================
module window_scan_ctrl #(
  parameter int NTAPS = cnn_stream_pkg::NTAPS,
  parameter int DW    = cnn_stream_pkg::DW,
  parameter int SW    = cnn_stream_pkg::SW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       win_valid,
  input  logic [0:NTAPS-1][DW-1:0]   win_data,
  output logic                       win_ready,
  output logic [0:NTAPS-1][DW-1:0]   mux_data_in,
  output logic [SW-1:0]              mux_sel,
  output logic                       tap_valid,
  output logic [SW-1:0]              tap_idx,
  output logic                       tap_last,
  output logic [15:0]                win_count,
  output logic                       busy
);

  import cnn_stream_pkg::*;

  localparam logic [SW-1:0] LAST_SEL = SW'(NTAPS - 1);

  scan_state_e                 state_q, state_d;
  logic [SW-1:0]               mux_sel_q, mux_sel_d;
  logic [0:NTAPS-1][DW-1:0]    buf_q, buf_d;
  logic                        tap_valid_q, tap_valid_d;
  logic [SW-1:0]               tap_idx_q, tap_idx_d;
  logic                        tap_last_q, tap_last_d;
  logic [15:0]                 win_count_q, win_count_d;

  logic                        at_last;
  logic                        accept;

  always_comb begin
    at_last     = (state_q == ST_SCAN) && (mux_sel_q == LAST_SEL);
    win_ready   = !reset && ((state_q == ST_IDLE) || at_last);
    accept      = win_valid && win_ready;

    state_d     = state_q;
    mux_sel_d   = mux_sel_q;
    buf_d       = buf_q;
    win_count_d = win_count_q;

    // Status flags trail the select by one cycle to line up with the selector.
    tap_valid_d = (state_q == ST_SCAN);
    tap_idx_d   = mux_sel_q;
    tap_last_d  = at_last;

    case (state_q)
      ST_IDLE: begin
        mux_sel_d = SW'(IDLE_SEL);
        if (accept) begin
          state_d   = ST_SCAN;
          mux_sel_d = '0;
          buf_d     = win_data;
        end
      end
      ST_SCAN: begin
        if (at_last) begin
          win_count_d = win_count_q + 16'd1;
          if (accept) begin
            // The selector samples the old last tap on this same edge.
            mux_sel_d = '0;
            buf_d     = win_data;
          end else begin
            state_d   = ST_IDLE;
            mux_sel_d = SW'(IDLE_SEL);
          end
        end else begin
          mux_sel_d = mux_sel_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mux_sel_d = SW'(IDLE_SEL);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mux_sel_q   <= SW'(IDLE_SEL);
      buf_q       <= '0;
      tap_valid_q <= 1'b0;
      tap_idx_q   <= '0;
      tap_last_q  <= 1'b0;
      win_count_q <= '0;
    end else begin
      state_q     <= state_d;
      mux_sel_q   <= mux_sel_d;
      buf_q       <= buf_d;
      tap_valid_q <= tap_valid_d;
      tap_idx_q   <= tap_idx_d;
      tap_last_q  <= tap_last_d;
      win_count_q <= win_count_d;
    end
  end

  assign mux_data_in = buf_q;
  assign mux_sel     = mux_sel_q;
  assign tap_valid   = tap_valid_q;
  assign tap_idx     = tap_idx_q;
  assign tap_last    = tap_last_q;
  assign win_count   = win_count_q;
  assign busy        = (state_q == ST_SCAN);

endmodule
`default_nettype wire

// File: tb/tb_window_scan_ctrl.sv
`default_nettype none
// ============================================================================
// tb_window_scan_ctrl : scoreboard bench with a model of the registered 9:1
// selector that sits beside the controller.
// Rev 1.0
// ============================================================================
module tb_window_scan_ctrl;

  localparam int C_N  = 9;
  localparam int C_DW = 8;
  localparam int C_SW = 5;

  typedef struct {
    logic [C_DW-1:0] data;
    logic [C_SW-1:0] idx;
    logic            last;
  } exp_t;

  logic                     clk;
  logic                     reset;
  logic                     win_valid;
  logic [0:C_N-1][C_DW-1:0] win_data;
  logic                     win_ready;
  logic [0:C_N-1][C_DW-1:0] mux_data_in;
  logic [C_SW-1:0]          mux_sel;
  logic                     tap_valid;
  logic [C_SW-1:0]          tap_idx;
  logic                     tap_last;
  logic [15:0]              win_count;
  logic                     busy;

  logic [C_DW-1:0]          sel_q;
  exp_t                     exp_q[$];
  int                       vecs;
  int                       errs;

  window_scan_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .win_valid   (win_valid),
    .win_data    (win_data),
    .win_ready   (win_ready),
    .mux_data_in (mux_data_in),
    .mux_sel     (mux_sel),
    .tap_valid   (tap_valid),
    .tap_idx     (tap_idx),
    .tap_last    (tap_last),
    .win_count   (win_count),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered selector: out-of-range selects leave the output holding.
  always @(posedge clk) begin
    if (mux_sel < C_SW'(C_N)) sel_q <= mux_data_in[mux_sel];
  end

  function automatic logic [C_N*C_DW-1:0] win_of(input logic [C_DW-1:0] base);
    logic [0:C_N-1][C_DW-1:0] w;
    for (int i = 0; i < C_N; i++) w[i] = base + C_DW'(i);
    return w;
  endfunction

  task automatic chk(input string name, input logic [C_N*C_DW-1:0] act,
                     input logic [C_N*C_DW-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_win(input logic [C_DW-1:0] base, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data = base + C_DW'(i);
      e.idx  = C_SW'(i);
      e.last = (i == C_N - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic offer(input logic [C_DW-1:0] base);
    win_data  = win_of(base);
    win_valid = 1'b1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every valid tap on the selector output pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (tap_valid === 1'b1) begin
      vecs++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL tap_unexpected: got idx %0d data %0h expected no tap", tap_idx, sel_q);
      end else begin
        e = exp_q.pop_front();
        if (sel_q !== e.data || tap_idx !== e.idx || tap_last !== e.last) begin
          errs++;
          $display("FAIL tap: got data %0h idx %0d last %0b expected data %0h idx %0d last %0b",
                   sel_q, tap_idx, tap_last, e.data, e.idx, e.last);
        end
      end
    end
  end

  initial begin
    vecs      = 0;
    errs      = 0;
    reset     = 1'b1;
    win_valid = 1'b1;
    win_data  = win_of(8'hA0);

    // Reset held with a window on offer: nothing may be taken.
    step(3);
    chk("ready_in_reset", 72'(win_ready), 72'd0);
    chk("busy_in_reset", 72'(busy), 72'd0);
    chk("sel_reset", 72'(mux_sel), 72'd31);
    chk("buf_reset", mux_data_in, 72'd0);
    chk("tapv_reset", 72'(tap_valid), 72'd0);
    chk("tapi_reset", 72'(tap_idx), 72'd0);
    chk("tapl_reset", 72'(tap_last), 72'd0);
    chk("count_reset", 72'(win_count), 72'd0);
    reset     = 1'b0;
    win_valid = 1'b0;
    #1;
    chk("ready_after_reset", 72'(win_ready), 72'd1);

    // Single window 0x10..0x18.
    offer(8'h10);
    push_win(8'h10, C_N);
    step(1);
    win_valid = 1'b0;
    chk("buf_single", mux_data_in, win_of(8'h10));
    for (int i = 0; i < C_N; i++) begin
      chk("sel_walk", 72'(mux_sel), 72'(i));
      step(1);
    end
    chk("sel_parked", 72'(mux_sel), 72'd31);
    chk("count_single", 72'(win_count), 72'd1);
    chk("busy_idle", 72'(busy), 72'd0);
    step(2);

    // Back-to-back A then B with win_valid held high.
    offer(8'h20);
    push_win(8'h20, C_N);
    push_win(8'h30, C_N);
    step(1);
    win_data = win_of(8'h30);
    for (int k = 1; k <= 2 * C_N; k++) begin
      step(1);
      if (k == C_N) win_valid = 1'b0;
      chk("b2b_contig", 72'(tap_valid), 72'd1);
    end
    step(2);
    chk("count_b2b", 72'(win_count), 72'd3);

    // Early offer at mux_sel 3 waits for the final tap.
    offer(8'h40);
    push_win(8'h40, C_N);
    push_win(8'h50, C_N);
    step(1);
    win_valid = 1'b0;
    step(3);
    offer(8'h50);
    for (int s = 3; s < C_N - 1; s++) begin
      chk("early_ready_low", 72'(win_ready), 72'd0);
      chk("early_buf_hold", mux_data_in, win_of(8'h40));
      step(1);
    end
    chk("early_ready_last", 72'(win_ready), 72'd1);
    step(1);
    win_valid = 1'b0;
    chk("early_buf_load", mux_data_in, win_of(8'h50));
    chk("early_sel0", 72'(mux_sel), 72'd0);
    step(C_N + 2);
    chk("count_early", 72'(win_count), 72'd5);

    // Reset at mux_sel 4: only taps 0..3 ever reach the output as valid.
    offer(8'h60);
    push_win(8'h60, 4);
    step(1);
    win_valid = 1'b0;
    step(4);
    chk("sel_before_abort", 72'(mux_sel), 72'd4);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("abort_busy", 72'(busy), 72'd0);
    chk("abort_sel", 72'(mux_sel), 72'd31);
    chk("abort_count", 72'(win_count), 72'd0);
    chk("abort_tapv", 72'(tap_valid), 72'd0);
    step(1);
    chk("abort_tapv2", 72'(tap_valid), 72'd0);
    chk("abort_idle", 72'(busy), 72'd0);

    // Counter wrap via backdoor preload to 65535.
    offer(8'h70);
    push_win(8'h70, C_N);
    step(1);
    win_valid = 1'b0;
    step(2);
    force dut.win_count_q = 16'hFFFF;
    #1;
    release dut.win_count_q;
    chk("wrap_preload", 72'(win_count), 72'hFFFF);
    step(7);
    chk("wrap_zero", 72'(win_count), 72'd0);
    step(3);

    chk("queue_drained", 72'(exp_q.size()), 72'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/window_scan_ctrl.md
WINDOW_SCAN_CTRL -- requirements
Module: window_scan_ctrl

Interface
REQ-001 Parameters SHALL be: NTAPS, default 9, taps per window; DW, default 8, tap width; SW, default 5, select width.
REQ-002 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port win_valid  input  1  upstream offers a 3x3 window.
REQ-005 Port win_data  input  [0:NTAPS-1][DW-1:0]  window taps, index 0 = top-left, raster order.
REQ-006 Port win_ready  output  1  block accepts a window this cycle.
REQ-007 Port mux_data_in  output  [0:NTAPS-1][DW-1:0]  held window, drives the downstream 9:1 registered selector.
REQ-008 Port mux_sel  output  [SW-1:0]  tap select to the selector.
REQ-009 Port tap_valid  output  1  selector output is valid this cycle.
REQ-010 Port tap_idx  output  [SW-1:0]  index of the tap currently on the selector output.
REQ-011 Port tap_last  output  1  current tap is index NTAPS-1.
REQ-012 Port win_count  output  16  windows fully scanned since reset.
REQ-013 Port busy  output  1  high while in SCAN.

Function
REQ-014 The FSM SHALL have two states: IDLE and SCAN.
REQ-015 The block SHALL accept a window when win_valid and win_ready are both high on a rising edge; the transfer SHALL load win_data into the window buffer, set mux_sel to 0 and enter SCAN.
REQ-016 win_ready SHALL be high in IDLE and in SCAN when mux_sel == NTAPS-1; it SHALL be low otherwise, including while reset is high.
REQ-017 In SCAN, mux_sel SHALL increment by 1 each cycle, from 0 to NTAPS-1, with no stall.
REQ-018 In SCAN with mux_sel == NTAPS-1: if a window is accepted, mux_sel SHALL return to 0 and the state SHALL stay SCAN; otherwise the state SHALL go to IDLE.
REQ-019 Back-to-back windows SHALL scan every NTAPS cycles without a gap.
REQ-020 The buffer reload on the final-tap edge SHALL NOT corrupt tap NTAPS-1 of the old window, because the selector samples the old value on that same edge.
REQ-021 In IDLE, mux_sel SHALL be parked at all-ones (31), which the selector ignores, so the selector output holds.
REQ-022 The buffer SHALL change only on an accepted window.
REQ-023 tap_valid, tap_idx and tap_last SHALL be registered copies of (state==SCAN), mux_sel and (mux_sel==NTAPS-1). This gives 1-cycle alignment with the registered selector output.
REQ-024 win_count SHALL increment by 1 on each edge where state==SCAN and mux_sel==NTAPS-1; it SHALL wrap from 65535 to 0.
REQ-025 win_valid asserted in SCAN before the final tap SHALL be ignored; the upstream block SHALL hold the window until win_ready is high.

Reset
REQ-026 On reset, the block SHALL set: state=IDLE, mux_sel=31, buffer=0, tap_valid=0, tap_last=0, tap_idx=0, win_count=0, busy=0.
REQ-027 Reset mid-scan SHALL abort the window without a partial count. tap_valid SHALL be 0 on the first cycle after reset deasserts; stale selector data SHALL be ignored downstream.
REQ-028 A window offered while reset is high SHALL NOT be accepted.

Structure
REQ-029 NTAPS, DW, SW, the idle select constant (31) and the state enum SHALL reside in a shared package, cnn_stream_pkg.
REQ-030 The block SHALL be one module with no sub-modules. The 9:1 selector SHALL be instantiated beside it by the parent, not inside it.

Verification
REQ-031 Single window: reset, offer win_data = 0x10..0x18 for one cycle -> mux_sel 0..8 on consecutive cycles; tap_valid high 9 cycles, starting 1 cycle later; selector outputs 0x10..0x18 in order; tap_last only with 0x18; win_count=1; mux_sel=31 afterwards.
REQ-032 Back-to-back: win_valid held high with windows A=0x20.. and B=0x30.. -> 18 contiguous tap_valid cycles; 0x28 is immediately followed by 0x30; win_count=2.
REQ-033 Early offer: win_valid asserted when mux_sel=3 -> win_ready low, buffer unchanged until the mux_sel=8 cycle, then the window is accepted.
REQ-034 Reset mid-scan: reset asserted at mux_sel=4 -> next cycle state=IDLE, mux_sel=31, win_count unchanged (0); tap_valid low after reset.
REQ-035 Counter wrap: force 65535 windows (or preload via backdoor) -> next completed window gives win_count=0.
REQ-036 Reset with win_valid high -> no acceptance; win_ready low during reset, high on the first cycle after release.
